// File: rtl/wb_soc_functions_pkg.sv
// Shared helpers for the SoC utility blocks: width calculation and the ASCII
// constants used by the number formatters.
package wb_soc_functions;

    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_NINE  = 8'd57;

    // Bits needed to hold any value in 0..value-1, never less than one bit.
    function automatic int clog2_width(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Decimal digits of 2^width-1. 30103/100000 approximates log10(2) closely
    // enough that no width up to 64 lands on the wrong side of an integer.
    function automatic int max_decimal_digits(input int width);
        return ((width * 30103) / 100000) + 1;
    endfunction

endpackage

// File: rtl/wb_soc_bcd_adj3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module wb_soc_bcd_adj3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/wb_soc_int2ascii.sv
// Sequential unsigned binary to fixed-width ASCII decimal converter using
// iterative shift-add-3, with leading-zero suppression and overflow saturation.
module wb_soc_int2ascii
    import wb_soc_functions::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int DIGITS     = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [DATA_WIDTH-1:0]               in_data_i,
    input  logic                                in_suppress_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [8*DIGITS-1:0]                 out_str_o,
    output logic [clog2_width(DIGITS+1)-1:0]    out_len_o,
    output logic                                out_ovf_o
);

    localparam int CNT_W = clog2_width(DATA_WIDTH);
    localparam int LEN_W = clog2_width(DIGITS + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int STR_W = 8 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_FORMAT,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]     bcd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 suppress_q;
    logic                 ovf_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [STR_W-1:0]     str_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovf_out_q;

    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     bcd_d;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                 ovf_shift;
    logic [STR_W-1:0]     str_d;
    logic [LEN_W-1:0]     len_d;
    logic [LEN_W-1:0]     lead_zeros;
    logic                 leading;
    logic [3:0]           nib;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        wb_soc_bcd_adj3 u_adj (
            .digit_i (bcd_q[4*g +: 4]),
            .digit_o (bcd_adj[4*g +: 4])
        );
    end

    // The bit falling off the top digit means the value no longer fits.
    assign {ovf_shift, bcd_d, shift_d} = {bcd_adj, shift_q, 1'b0};

    // Leading zeros are counted on the top DIGITS-1 characters only, so the
    // units digit always survives and a zero value still prints as '0'.
    always_comb begin
        str_d      = '0;
        lead_zeros = '0;
        leading    = 1'b1;
        nib        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if (leading && (i != 0) && (nib == 4'd0)) begin
                lead_zeros       = lead_zeros + LEN_W'(1);
                str_d[8*i +: 8] = suppress_q ? ASCII_SPACE : ASCII_ZERO;
            end else begin
                leading          = 1'b0;
                str_d[8*i +: 8] = ASCII_ZERO + {4'd0, nib};
            end
            if (ovf_q) begin
                str_d[8*i +: 8] = ASCII_NINE;
            end
        end
        len_d = ovf_q ? LEN_W'(DIGITS) : (LEN_W'(DIGITS) - lead_zeros);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            suppress_q  <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            str_q       <= '0;
            len_q       <= '0;
            ovf_out_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        shift_q    <= in_data_i;
                        suppress_q <= in_suppress_i;
                        bcd_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= CNT_W'(DATA_WIDTH - 1);
                        in_ready_q <= 1'b0;
                        state_q    <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    shift_q <= shift_d;
                    bcd_q   <= bcd_d;
                    ovf_q   <= ovf_q | ovf_shift;
                    if (cnt_q == '0) begin
                        state_q <= S_FORMAT;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FORMAT: begin
                    str_q       <= str_d;
                    len_q       <= len_d;
                    ovf_out_q   <= ovf_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_str_o   = str_q;
    assign out_len_o   = len_q;
    assign out_ovf_o   = ovf_out_q;

endmodule

// File: tb/tb_wb_soc_int2ascii.sv
// Bench for wb_soc_int2ascii: a default 10-bit/3-digit instance and a
// 16-bit/5-digit instance, checked against an arithmetic decimal model.
module tb_wb_soc_int2ascii;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration instance
    logic        rstA;
    logic        inValidA;
    logic        inReadyA;
    logic [9:0]  inDataA;
    logic        inSupA;
    logic        outValidA;
    logic        outReadyA;
    logic [23:0] outStrA;
    logic [1:0]  outLenA;
    logic        outOvfA;

    // Wide configuration instance
    logic        rstB;
    logic        inValidB;
    logic        inReadyB;
    logic [15:0] inDataB;
    logic        inSupB;
    logic        outValidB;
    logic        outReadyB;
    logic [39:0] outStrB;
    logic [2:0]  outLenB;
    logic        outOvfB;

    int checks = 0;
    int failures = 0;

    wb_soc_int2ascii #(.DATA_WIDTH(10), .DIGITS(3)) dutA (
        .clk_i         (clk),
        .rst_i         (rstA),
        .in_valid_i    (inValidA),
        .in_ready_o    (inReadyA),
        .in_data_i     (inDataA),
        .in_suppress_i (inSupA),
        .out_valid_o   (outValidA),
        .out_ready_i   (outReadyA),
        .out_str_o     (outStrA),
        .out_len_o     (outLenA),
        .out_ovf_o     (outOvfA)
    );

    wb_soc_int2ascii #(.DATA_WIDTH(16), .DIGITS(5)) dutB (
        .clk_i         (clk),
        .rst_i         (rstB),
        .in_valid_i    (inValidB),
        .in_ready_o    (inReadyB),
        .in_data_i     (inDataB),
        .in_suppress_i (inSupB),
        .out_valid_o   (outValidB),
        .out_ready_i   (outReadyB),
        .out_str_o     (outStrB),
        .out_len_o     (outLenB),
        .out_ovf_o     (outOvfB)
    );

    // Decimal formatting from plain division: saturate at 10^digits, otherwise
    // print each digit and pad the unused high positions.
    function automatic void modelConvert(input longint unsigned v, input int digits, input bit sup,
                                         output logic [39:0] str, output int len, output bit ovf);
        longint unsigned limit;
        longint unsigned rem;
        int nd;
        limit = 1;
        for (int k = 0; k < digits; k++) limit = limit * 10;
        str = '0;
        ovf = (v >= limit);
        if (ovf) begin
            for (int k = 0; k < digits; k++) str[8*k +: 8] = 8'd57;
            len = digits;
            return;
        end
        nd = 1;
        rem = v / 10;
        while (rem != 0) begin
            nd++;
            rem = rem / 10;
        end
        rem = v;
        for (int k = 0; k < digits; k++) begin
            if (k < nd) str[8*k +: 8] = 8'(48 + (rem % 10));
            else        str[8*k +: 8] = sup ? 8'd32 : 8'd48;
            rem = rem / 10;
        end
        len = nd;
    endfunction

    // Offers one value to instance A and waits for its result; returns at the
    // falling edge where out_valid is first seen high.
    task automatic driveA(input logic [9:0] v, input bit sup,
                          output int lat, output int acceptCycle, output bit timedOut);
        int waitCnt;
        waitCnt = 0;
        timedOut = 1'b0;
        lat = 0;
        acceptCycle = 0;
        @(negedge clk);
        while (!inReadyA && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReadyA) begin
            timedOut = 1'b1;
            return;
        end
        inValidA = 1'b1;
        inDataA = v;
        inSupA = sup;
        @(posedge clk);
        acceptCycle = int'($time / 10);
        #1;
        inValidA = 1'b0;
        inDataA = 'x;
        inSupA = 1'bx;
        forever begin
            @(negedge clk);
            if (outValidA) break;
            @(posedge clk);
            lat++;
            if (lat > 200) begin
                timedOut = 1'b1;
                break;
            end
        end
    endtask

    task automatic driveB(input logic [15:0] v, input bit sup,
                          output int lat, output bit timedOut);
        int waitCnt;
        waitCnt = 0;
        timedOut = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!inReadyB && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!inReadyB) begin
            timedOut = 1'b1;
            return;
        end
        inValidB = 1'b1;
        inDataB = v;
        inSupB = sup;
        @(posedge clk);
        #1;
        inValidB = 1'b0;
        inDataB = 'x;
        inSupB = 1'bx;
        forever begin
            @(negedge clk);
            if (outValidB) break;
            @(posedge clk);
            lat++;
            if (lat > 200) begin
                timedOut = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstA = 1'b1;
        rstB = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({inReadyA, outValidA, outStrA, outLenA, outOvfA} !== {1'b1, 1'b0, 24'd0, 2'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL resetA: got rdy=%b vld=%b str=%h len=%0d ovf=%b, exp rdy=1 vld=0 str=0 len=0 ovf=0",
                     inReadyA, outValidA, outStrA, outLenA, outOvfA);
        end
        checks++;
        if ({inReadyB, outValidB, outStrB, outLenB, outOvfB} !== {1'b1, 1'b0, 40'd0, 3'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL resetB: got rdy=%b vld=%b str=%h len=%0d ovf=%b, exp rdy=1 vld=0 str=0 len=0 ovf=0",
                     inReadyB, outValidB, outStrB, outLenB, outOvfB);
        end
        rstA = 1'b0;
        rstB = 1'b0;
    endtask

    task automatic test_directed_a();
        logic [9:0]  dirVal [6] = '{10'd999, 10'd1000, 10'd1023, 10'd42, 10'd42, 10'd0};
        bit          dirSup [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [23:0] dirStr [6] = '{"999", "999", "999", " 42", "042", "  0"};
        int          dirLen [6] = '{3, 3, 3, 2, 2, 1};
        bit          dirOvf [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        int acc;
        bit timedOut;
        outReadyA = 1'b1;
        for (int i = 0; i < 6; i++) begin
            driveA(dirVal[i], dirSup[i], lat, acc, timedOut);
            checks++;
            if (timedOut) begin
                failures++;
                $display("[TB] FAIL directedA_timeout[%0d]: got no out_valid, exp result within bound", i);
                continue;
            end
            checks++;
            if (lat != 11) begin
                failures++;
                $display("[TB] FAIL directedA_latency[%0d]: got %0d exp 11", i, lat);
            end
            checks++;
            if (outStrA !== dirStr[i]) begin
                failures++;
                $display("[TB] FAIL directedA_str[%0d]: got %h exp %h", i, outStrA, dirStr[i]);
            end
            checks++;
            if (outLenA !== 2'(dirLen[i])) begin
                failures++;
                $display("[TB] FAIL directedA_len[%0d]: got %0d exp %0d", i, outLenA, dirLen[i]);
            end
            checks++;
            if (outOvfA !== dirOvf[i]) begin
                failures++;
                $display("[TB] FAIL directedA_ovf[%0d]: got %b exp %b", i, outOvfA, dirOvf[i]);
            end
        end
    endtask

    task automatic test_random_a();
        logic [9:0]  v;
        bit          sup;
        logic [39:0] expStr;
        int          expLen;
        bit          expOvf;
        int lat;
        int acc;
        bit timedOut;
        outReadyA = 1'b1;
        for (int i = 0; i < 25; i++) begin
            v = 10'($urandom_range(1023, 0));
            sup = 1'($urandom_range(1, 0));
            modelConvert(longint'(v), 3, sup, expStr, expLen, expOvf);
            driveA(v, sup, lat, acc, timedOut);
            checks++;
            if (timedOut || lat != 11) begin
                failures++;
                $display("[TB] FAIL randomA_latency v=%0d: got %0d (timeout=%b) exp 11", v, lat, timedOut);
                continue;
            end
            checks++;
            if ({outStrA, outLenA, outOvfA} !== {expStr[23:0], 2'(expLen), expOvf}) begin
                failures++;
                $display("[TB] FAIL randomA v=%0d sup=%b: got str=%h len=%0d ovf=%b exp str=%h len=%0d ovf=%b",
                         v, sup, outStrA, outLenA, outOvfA, expStr[23:0], expLen, expOvf);
            end
        end
    endtask

    task automatic test_back_to_back_a();
        int lat;
        int acc1;
        int acc2;
        bit to1;
        bit to2;
        outReadyA = 1'b1;
        driveA(10'd123, 1'b0, lat, acc1, to1);
        driveA(10'd7, 1'b1, lat, acc2, to2);
        checks++;
        if (to1 || to2 || (acc2 - acc1) != 13) begin
            failures++;
            $display("[TB] FAIL b2bA_interval: got %0d (timeout=%b%b) exp 13", acc2 - acc1, to1, to2);
        end
        checks++;
        if ({outStrA, outLenA, outOvfA} !== {24'h202037, 2'd1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL b2bA_result: got str=%h len=%0d ovf=%b exp str=202037 len=1 ovf=0",
                     outStrA, outLenA, outOvfA);
        end
    endtask

    task automatic test_backpressure_b();
        logic [39:0] hold = "65535";
        int lat;
        bit timedOut;
        outReadyB = 1'b0;
        driveB(16'd65535, 1'b0, lat, timedOut);
        checks++;
        if (timedOut || lat != 17) begin
            failures++;
            $display("[TB] FAIL bpB_latency: got %0d (timeout=%b) exp 17", lat, timedOut);
        end
        checks++;
        if ({outStrB, outLenB, outOvfB} !== {hold, 3'd5, 1'b0}) begin
            failures++;
            $display("[TB] FAIL bpB_result: got str=%h len=%0d ovf=%b exp str=%h len=5 ovf=0",
                     outStrB, outLenB, outOvfB, hold);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({outValidB, inReadyB, outStrB, outLenB, outOvfB} !== {1'b1, 1'b0, hold, 3'd5, 1'b0}) begin
                failures++;
                $display("[TB] FAIL bpB_hold[%0d]: got vld=%b rdy=%b str=%h len=%0d ovf=%b exp vld=1 rdy=0 str=%h len=5 ovf=0",
                         c, outValidB, inReadyB, outStrB, outLenB, outOvfB, hold);
            end
        end
        outReadyB = 1'b1;
        @(negedge clk);
        checks++;
        if ({inReadyB, outValidB, outStrB} !== {1'b1, 1'b0, hold}) begin
            failures++;
            $display("[TB] FAIL bpB_release: got rdy=%b vld=%b str=%h exp rdy=1 vld=0 str=%h",
                     inReadyB, outValidB, outStrB, hold);
        end
        driveB(16'd7, 1'b1, lat, timedOut);
        checks++;
        if (timedOut || {outStrB, outLenB, outOvfB} !== {40'h2020202037, 3'd1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL bpB_next: got str=%h len=%0d ovf=%b (timeout=%b) exp str=2020202037 len=1 ovf=0",
                     outStrB, outLenB, outOvfB, timedOut);
        end
    endtask

    task automatic test_random_b();
        logic [15:0] v;
        bit          sup;
        logic [39:0] expStr;
        int          expLen;
        bit          expOvf;
        int lat;
        bit timedOut;
        outReadyB = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 16'd0 : 16'($urandom_range(65535, 0) >> $urandom_range(15, 0));
            sup = 1'($urandom_range(1, 0));
            modelConvert(longint'(v), 5, sup, expStr, expLen, expOvf);
            driveB(v, sup, lat, timedOut);
            checks++;
            if (timedOut || {outStrB, outLenB, outOvfB} !== {expStr, 3'(expLen), expOvf}) begin
                failures++;
                $display("[TB] FAIL randomB v=%0d sup=%b: got str=%h len=%0d ovf=%b (timeout=%b) exp str=%h len=%0d ovf=%b",
                         v, sup, outStrB, outLenB, outOvfB, timedOut, expStr, expLen, expOvf);
            end
        end
    endtask

    task automatic test_async_reset();
        int waitCnt;
        int lat;
        int acc;
        bit timedOut;
        waitCnt = 0;
        outReadyA = 1'b1;
        @(negedge clk);
        while (!inReadyA && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        inValidA = 1'b1;
        inDataA = 10'd1023;
        inSupA = 1'b0;
        @(posedge clk);
        #1;
        inValidA = 1'b0;
        inDataA = 'x;
        inSupA = 1'bx;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (inReadyA !== 1'b0) begin
            failures++;
            $display("[TB] FAIL asyncA_busy: got rdy=%b exp 0", inReadyA);
        end
        rstA = 1'b1;
        #1;
        checks++;
        if ({inReadyA, outValidA, outStrA, outLenA, outOvfA} !== {1'b1, 1'b0, 24'd0, 2'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL asyncA_reset: got rdy=%b vld=%b str=%h len=%0d ovf=%b exp rdy=1 vld=0 str=0 len=0 ovf=0",
                     inReadyA, outValidA, outStrA, outLenA, outOvfA);
        end
        @(negedge clk);
        rstA = 1'b0;
        driveA(10'd5, 1'b0, lat, acc, timedOut);
        checks++;
        if (timedOut || lat != 11 || {outStrA, outLenA, outOvfA} !== {24'h303035, 2'd1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL asyncA_after: got str=%h len=%0d ovf=%b lat=%0d (timeout=%b) exp str=303035 len=1 ovf=0 lat=11",
                     outStrA, outLenA, outOvfA, lat, timedOut);
        end
    endtask

    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        inValidA = 1'b0;
        inValidB = 1'b0;
        inDataA = 'x;
        inDataB = 'x;
        inSupA = 1'bx;
        inSupB = 1'bx;
        outReadyA = 1'b1;
        outReadyB = 1'b1;
        test_reset();
        test_directed_a();
        test_random_a();
        test_back_to_back_a();
        test_backpressure_b();
        test_random_b();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb_soc_int2ascii.md
Name: wb_soc_int2ascii

Overview:
- Sequential, parametrised successor to the fixed 3-digit combinational integer-to-string helper.
- Converts an unsigned DATA_WIDTH-bit binary value into DIGITS ASCII decimal characters using iterative double-dabble (shift-add-3).
- Supports optional leading-zero suppression, overflow detection and saturation, and valid/ready handshakes on both sides.
- Used by SoC debug/console peripherals to format counters and indices for UART/trace output.

Parameters:
- DATA_WIDTH, 10, width of binary input; legal 1..64.
- DIGITS, 3, number of output decimal characters; legal 1..20.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- in_valid_i  in  1  input value valid.
- in_ready_o  out  1  block can accept a value.
- in_data_i  in  DATA_WIDTH  unsigned value to convert.
- in_suppress_i  in  1  replace leading zeros with ASCII space; sampled with in_data_i.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- out_str_o  out  8*DIGITS  ASCII string, most significant character in the top byte.
- out_len_o  out  clog2_width(DIGITS+1)  count of significant (non-space) characters, 1..DIGITS.
- out_ovf_o  out  1  value was at least 10^DIGITS; string is saturated.

Behaviour:
- Reset (asynchronous, any state, including mid-conversion) sets:
  - state to IDLE, in_ready_o=1, out_valid_o=0, out_str_o=0, out_len_o=0, out_ovf_o=0;
  - shift and BCD registers and the bit counter to 0.
- State IDLE:
  - in_ready_o=1.
  - When in_valid_i && in_ready_o at an edge:
    - capture in_data_i into the shift register and in_suppress_i into a flag;
    - clear the BCD register (4*DIGITS bits) and the sticky overflow bit;
    - load the counter with DATA_WIDTH-1 (width clog2_width(DATA_WIDTH));
    - go to CONVERT.
- State CONVERT: one iteration per cycle.
  - Every BCD nibble >=5 gets +3.
  - Then {ovf_shift, bcd, shift} is shifted left by 1.
  - If the bit leaving the top of bcd is 1, the sticky overflow bit is set.
  - When the counter reaches 0 at an edge, go to FORMAT; otherwise decrement.
  - Exactly DATA_WIDTH iterations.
- State FORMAT: one cycle; registers the outputs.
  - Each nibble becomes ASCII '0'+nibble.
  - If overflow: all characters become '9', out_len_o=DIGITS, out_ovf_o=1.
  - Else, if suppress is set: leading zero characters become ' '. The least significant character is never suppressed, so value 0 gives '0' with len 1.
  - out_len_o = DIGITS minus the number of leading zeros, minimum 1. It is computed regardless of suppress.
  - Go to DONE.
- State DONE:
  - out_valid_o=1.
  - Outputs stay stable while out_ready_i=0 (backpressure, unbounded).
  - On out_ready_i at an edge: out_valid_o drops and state goes to IDLE. Outputs keep their last value.
- Timing:
  - in_ready_o=0 in CONVERT, FORMAT and DONE; one conversion is in flight at a time.
  - Latency: out_valid_o rises DATA_WIDTH+1 clocks after the accepting edge.
  - Minimum initiation interval is DATA_WIDTH+3 clocks with out_ready_i held high.
- in_data_i and in_suppress_i are ignored when not accepted. X on the inputs while in_valid_i=0 must not propagate.
- Width rules:
  - BCD add-3 is nibble-local, 4-bit with no carry between nibbles.
  - The overflow bit is sticky across the whole conversion.
  - DIGITS large enough for DATA_WIDTH can never overflow; the logic stays, and out_ovf_o remains 0.

Decomposition:
- Add to wb_soc_functions:
  - constants ASCII_ZERO=8'd48 and ASCII_SPACE=8'd32;
  - function max_decimal_digits(width), returning the number of digits needed for 2^width-1.
- Use clog2_width from the same package for the counter and out_len_o widths.
- State enum typedef is local to the module.
- One combinational sub-module: wb_soc_bcd_adj3 (4-bit in, 4-bit out, +3 when >=5), instantiated DIGITS times in a generate loop.

Test Plan:
- Default params, in=999, suppress=0: out_str="999", len=3, ovf=0. out_valid_o rises exactly 11 clocks after accept.
- Default params, in=1000 and in=1023: out_str="999", ovf=1, len=3 for both.
- Default params, in=42, suppress=1: out_str=" 42", len=2. Same with suppress=0: "042", len=2.
- Default params, in=0, suppress=1: out_str="  0", len=1, ovf=0.
- DATA_WIDTH=16, DIGITS=5:
  - in=65535 gives "65535", ovf=0.
  - Hold out_ready_i=0 for 20 cycles: outputs stable and in_ready_o=0 throughout.
  - Release: in_ready_o=1 one cycle later; a back-to-back in=7, suppress=1 gives "    7".
- Assert rst_i asynchronously mid-CONVERT (cycle 4 of 10): all outputs return to reset values immediately. A new value of 5 afterwards converts correctly to "005" with no residue from the aborted conversion.
